// File: rtl/fpadd_pkg.sv
// Shared constants and helpers for the streaming FP adder wrapper.
// Field positions follow IEEE-754 single precision.
package fpadd_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam int unsigned MAN_MSB = 22;

  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned FLAG_NAN  = 2;
  localparam int unsigned FLAG_INF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  // Canonical quiet NaN, as produced by the adder for invalid operations.
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef logic [FP_W-1:0] fp_t;

  // Classify a result into {nan, inf, zero}.
  function automatic logic [FLAG_W-1:0] fp_flags(input fp_t v);
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    exp_ones = &v[EXP_MSB:EXP_LSB];
    exp_zero = ~|v[EXP_MSB:EXP_LSB];
    man_zero = ~|v[MAN_MSB:0];
    fp_flags            = '0;
    fp_flags[FLAG_NAN]  = exp_ones & ~man_zero;
    fp_flags[FLAG_INF]  = exp_ones & man_zero;
    fp_flags[FLAG_ZERO] = exp_zero & man_zero;
  endfunction

endpackage

// File: rtl/fpadd_stream_ctrl_fifo.sv
// In-order synchronous FIFO for completed results.
// Push and pop may coincide at any occupancy, including full.
module fpadd_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_wdata,
  output logic [Width-1:0] o_rdata,
  output logic [CntW-1:0]  o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(Depth));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;

  // Pointer and occupancy tracking; clear drops every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; zeroed on reset so the head reads as all-zero when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (i_push && !i_clr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/fpadd_stream_ctrl.sv
// Streaming valid/ready wrapper around a fixed-latency pipelined FP adder.
// Operands go straight to the adder; a valid/tag shift register marks which
// adder outputs are real, and a credit counter guarantees every in-flight
// result has a FIFO slot waiting for it.
// Optional build macro FPADD_FLAGS_EN adds out_flags = {nan, inf, zero}.
module fpadd_stream_ctrl
  import fpadd_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   in_a,
  input  logic [FP_W-1:0]   in_b,
  input  logic              in_as,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [FP_W-1:0]   add_a,
  output logic [FP_W-1:0]   add_b,
  output logic              add_as,
  input  logic [FP_W-1:0]   add_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   out_data,
  output logic [TAG_W-1:0]  out_tag,
`ifdef FPADD_FLAGS_EN
  output logic [FLAG_W-1:0] out_flags,
`endif
  output logic              busy
);

  localparam int unsigned RsvW = $clog2(DEPTH + 1);
`ifdef FPADD_FLAGS_EN
  localparam int unsigned EntW = FP_W + TAG_W + FLAG_W;
`else
  localparam int unsigned EntW = FP_W + TAG_W;
`endif

  logic               w_fire;
  logic               w_pop;
  logic               w_push;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [RsvW-1:0]    w_count;
  logic [RsvW-1:0]    r_reserved;
  logic [LATENCY-1:0] r_vsh;
  logic [TAG_W-1:0]   r_tsh [LATENCY];
  logic [EntW-1:0]    w_wdata;
  logic [EntW-1:0]    w_rdata;

  // The adder runs every cycle; only r_vsh says which outputs matter.
  assign add_a  = in_a;
  assign add_b  = in_b;
  assign add_as = in_as;

  // Credit check uses registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (r_reserved < RsvW'(DEPTH)) & ~flush;
  assign w_fire    = in_valid & in_ready;
  assign w_push    = r_vsh[LATENCY-1];
  assign out_valid = ~w_fifo_empty;
  assign w_pop     = out_valid & out_ready;
  assign busy      = (r_reserved != '0);

  // Valid and tag travel in lockstep with the adder pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vsh <= '0;
      for (int i = 0; i < LATENCY; i++) r_tsh[i] <= '0;
    end else begin
      r_vsh[0] <= w_fire & ~flush;
      r_tsh[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_vsh[i] <= r_vsh[i-1] & ~flush;
        r_tsh[i] <= r_tsh[i-1];
      end
    end
  end

  // Credits: FIFO occupancy plus operations still inside the adder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reserved <= '0;
    end else if (flush) begin
      r_reserved <= '0;
    end else begin
      case ({w_fire, w_pop})
        2'b10:   r_reserved <= r_reserved + RsvW'(1);
        2'b01:   r_reserved <= r_reserved - RsvW'(1);
        default: r_reserved <= r_reserved;
      endcase
    end
  end

`ifdef FPADD_FLAGS_EN
  assign w_wdata = {add_result, r_tsh[LATENCY-1], fp_flags(add_result)};
  assign {out_data, out_tag, out_flags} = w_rdata;
`else
  assign w_wdata = {add_result, r_tsh[LATENCY-1]};
  assign {out_data, out_tag} = w_rdata;
`endif

  fpadd_sync_fifo #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // A result arriving at a full FIFO would mean the credit scheme is broken.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && w_fifo_full));

  a_reserved_covers_fifo: assert property (@(posedge clk) disable iff (!rst)
    r_reserved >= w_count);

endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
// Scoreboard bench for fpadd_stream_ctrl with a behavioural 3-stage adder.
module tb_fpadd_stream_ctrl;
  import fpadd_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [2:0]  flags;
  } exp_t;

  logic        clk, rst, flush, in_valid, in_ready, in_as, add_as;
  logic [31:0] in_a, in_b, add_a, add_b, add_result, out_data;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, busy;
`ifdef FPADD_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  exp_t        exp_q[$];
  exp_t        cur_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_recv   = 0;
  logic [31:0] pipe [3];

  fpadd_stream_ctrl #(.LATENCY(3), .DEPTH(4), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_as      (in_as),
    .in_tag     (in_tag),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_as     (add_as),
    .add_result (add_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
`ifdef FPADD_FLAGS_EN
    .out_flags  (out_flags),
`endif
    .busy       (busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Exact integer-valued single-precision encoding (|v| < 2^24).
  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] r;
    int unsigned m;
    int          p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? int'(-v) : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(m << (23 - p));
    return r;
  endfunction

  function automatic int fp_to_int(input logic [31:0] f);
    int          p;
    int unsigned mag;
    if (f[30:23] == 8'h00) return 0;
    p   = int'(f[30:23]) - 127;
    mag = {8'h01, f[22:0]} >> (23 - p);
    return f[31] ? -int'(mag) : int'(mag);
  endfunction

  // Environment adder: integer-valued operands plus inf/NaN special cases.
  function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
    logic [31:0] bb;
    logic a_sp, b_sp;
    bb   = b ^ {s, 31'b0};
    a_sp = (a[30:23] == 8'hFF);
    b_sp = (bb[30:23] == 8'hFF);
    if ((a_sp && a[22:0] != 0) || (b_sp && bb[22:0] != 0)) return QNAN;
    if (a_sp && b_sp) return (a[31] != bb[31]) ? QNAN : a;
    if (a_sp) return a;
    if (b_sp) return bb;
    return int_to_fp(fp_to_int(a) + fp_to_int(bb));
  endfunction

  always @(posedge clk) begin
    pipe[0] <= fp_add_model(add_a, add_b, add_as);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign add_result = pipe[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard push: every accepted operation enqueues its expected result.
  initial forever begin
    @(negedge clk);
    if (rst && in_valid && in_ready) exp_q.push_back(cur_exp);
  end

  // Monitor: compare each delivered result and check head stability under stall.
  initial begin
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic [3:0]  prev_tag;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 0;
      end else if (flush) begin
        exp_q.delete();
        prev_stall = 0;
      end else begin
        if (prev_stall && out_valid) begin
          check("hold_data", out_data, prev_data);
          check("hold_tag", {28'b0, out_tag}, {28'b0, prev_tag});
        end
        if (out_valid && out_ready) begin
          n_recv++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out: got tag %0d data %h, required nothing", out_tag,
                     out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
`ifdef FPADD_FLAGS_EN
            check("out_flags", {29'b0, out_flags}, {29'b0, e.flags});
`endif
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
      end
    end
  end

  task automatic set_op(input int x, input int y, input bit s, input logic [3:0] tag);
    int sum;
    sum     = s ? x - y : x + y;
    in_a    = int_to_fp(x);
    in_b    = int_to_fp(y);
    in_as   = s;
    in_tag  = tag;
    cur_exp = '{int_to_fp(sum), tag, (sum == 0) ? 3'b001 : 3'b000};
  endtask

  // Offer one operation until accepted; called at posedge+1.
  task automatic send(input int x, input int y, input bit s, input logic [3:0] tag);
    int n   = 0;
    bit fired = 0;
    set_op(x, y, s, tag);
    in_valid = 1;
    while (!fired && n < 50) begin
      @(negedge clk);
      fired = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    check("send_accepted", {31'b0, fired}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {31'b0, (n < 200)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(2000)) - 1000;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  base;
    int  nf;
    bit  pending;
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_a = 0; in_b = 0; in_as = 0; in_tag = 0;
    cur_exp = '{32'h0, 4'h0, 3'b000};

    // Reset state, no clock edge needed
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
`ifdef FPADD_FLAGS_EN
    check("rst_flags", {29'b0, out_flags}, 32'd0);
`endif
    #10 rst = 1;
    @(posedge clk); #1;

    // 1: single op 1.0 + 2.0, result three cycles after the accepting edge
    out_ready = 1;
    send(1, 2, 0, 4'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_early", {31'b0, out_valid}, 32'd0);
    end
    @(negedge clk);
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check("single_data", out_data, 32'h4040_0000);
    @(posedge clk); #1;
    drain();

    // 2: backpressure, only DEPTH ops accepted, then ordered delivery
    base = n_recv;
    out_ready = 0;
    for (int t = 0; t < 4; t++) send(t + 1, rnd_val(), 0, 4'(t));
    set_op(100, 1, 0, 4'd4);
    in_valid = 1;
    nf = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (in_ready) nf++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("bp_stalled_fires", nf, 0);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1;
    for (int t = 4; t < 8; t++) send(t + 1, rnd_val(), 1, 4'(t));
    drain();
    check("bp_recv_count", n_recv - base, 8);

    // 3: fire and pop together at reserved=3
    out_ready = 0;
    for (int t = 8; t < 11; t++) send(rnd_val(), rnd_val(), 0, 4'(t));
    repeat (4) @(posedge clk);
    #1;
    set_op(7, 3, 1, 4'd11);
    in_valid = 1; out_ready = 1;
    @(negedge clk);
    check("fp_in_ready", {31'b0, in_ready}, 32'd1);
    check("fp_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    set_op(9, 9, 1, 4'd12);
    out_ready = 0;
    @(negedge clk);
    check("fp_still_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("fp_full_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    drain();

    // 4: flush with one result queued and two in flight
    out_ready = 0;
    send(11, 22, 0, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    send(33, 44, 0, 4'd2);
    send(55, 66, 0, 4'd3);
    flush = 1;
    @(negedge clk);
    check("fl_in_ready", {31'b0, in_ready}, 32'd0);
    check("fl_had_out", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("fl_out_valid", {31'b0, out_valid}, 32'd0);
    check("fl_busy", {31'b0, busy}, 32'd0);
    check("fl_in_ready_after", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    send(-5, 8, 0, 4'd13);
    drain();

    // 5: asynchronous reset between edges
    out_ready = 0;
    send(1, 1, 0, 4'd2);
    send(2, 2, 0, 4'd3);
    repeat (3) @(posedge clk);
    #3;
    check("rs_pre_valid", {31'b0, out_valid}, 32'd1);
    rst = 0;
    #1;
    check("rs_out_valid", {31'b0, out_valid}, 32'd0);
    check("rs_in_ready", {31'b0, in_ready}, 32'd1);
    check("rs_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1;
    @(posedge clk); #1;
    out_ready = 1;
    send(40, 2, 1, 4'd14);
    drain();

`ifdef FPADD_FLAGS_EN
    // 6: flag decode: inf + -inf -> qNaN, 1 - 1 -> +0
    in_a = 32'h7F80_0000; in_b = 32'hFF80_0000; in_as = 0; in_tag = 4'd6;
    cur_exp  = '{QNAN, 4'd6, 3'b100};
    in_valid = 1;
    @(negedge clk);
    check("nan_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    send(1, 1, 1, 4'd7);
    drain();
`endif

    // Randomized traffic with occasional flushes
    pending = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(3) != 0) begin
        set_op(rnd_val(), rnd_val(), 1'($urandom_range(1)), 4'($urandom_range(15)));
        in_valid = 1;
        pending  = 1;
      end
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(39) == 0);
      @(negedge clk);
      if (in_valid && in_ready) pending = 0;
      @(posedge clk); #1;
      if (!pending) in_valid = 0;
      flush = 0;
    end
    in_valid = 0;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
